ibex_irq_ctrl: RTL and testbench

- Parametrised interrupt arbitration and handshake block. It sits between the raw interrupt sources and ibex_controller.
- Generalises the fixed 15-line fast-interrupt input to NUM_FAST_IRQ lines. Adds edge-latched NMI, a prioritised request/ack handshake to the controller, a service-state tracker released by mret, and a saturating taken-interrupt counter.
- The controller consumes irq_req_o/irq_id_o in place of its current raw irq inputs.

---
 rtl/ibex_irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_ibex_irq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_irq_ctrl.sv
// Interrupt arbitration and request/ack handshake in front of ibex_controller.
// Prioritises NMI and level sources, tracks service until mret and counts taken irqs.
module ibex_irq_ctrl #(
    parameter int unsigned NUM_FAST_IRQ = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_external_i,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast_i,
    input  logic                    irq_nm_i,
    input  logic                    csr_mstatus_mie_i,
    input  logic [NUM_FAST_IRQ+2:0] csr_mie_i,
    input  logic                    debug_mode_i,
    input  logic                    irq_ack_i,
    input  logic                    mret_i,
    output logic                    irq_req_o,
    output logic [5:0]              irq_id_o,
    output logic                    irq_nm_o,
    output logic                    irq_pending_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        taken_cnt_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StReq    = 2'd1;
    localparam logic [1:0] StSvc    = 2'd2;
    localparam logic [1:0] StNmiSvc = 2'd3;

    localparam logic [5:0] IdNmi = 6'd63;

    logic [1:0]              state_q, state_d;
    logic [5:0]              id_q, id_d;
    logic                    nm_q, nm_d;
    logic                    nmi_pend_q, nmi_pend_d;
    logic                    nm_prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_FAST_IRQ+2:0] en;
    logic [5:0]              best_id;
    logic                    src_active;
    logic                    eligible;
    logic                    nmi_ack;

    // Bit order: timer, software, external, then fast lines.
    assign en = {irq_fast_i & csr_mie_i[3 +: NUM_FAST_IRQ],
                 irq_external_i & csr_mie_i[2],
                 irq_software_i & csr_mie_i[0],
                 irq_timer_i & csr_mie_i[1]};

    assign eligible = ~debug_mode_i & (nmi_pend_q | (csr_mstatus_mie_i & (|en)));

    // Later assignments override earlier ones, so lowest priority comes first.
    always_comb begin
        best_id = 6'd0;
        if (en[0]) best_id = 6'd7;
        if (en[1]) best_id = 6'd3;
        if (en[2]) best_id = 6'd11;
        for (int k = 0; k < NUM_FAST_IRQ; k++) begin
            if (en[3+k]) best_id = 6'(16 + k);
        end
        if (nmi_pend_q) best_id = IdNmi;
    end

    // Is the source behind the latched non-NMI id still enabled and asserted?
    always_comb begin
        src_active = 1'b0;
        if (id_q == 6'd7)  src_active = en[0];
        if (id_q == 6'd3)  src_active = en[1];
        if (id_q == 6'd11) src_active = en[2];
        for (int k = 0; k < NUM_FAST_IRQ; k++) begin
            if (id_q == 6'(16 + k)) src_active = en[3+k];
        end
    end

    assign nmi_ack    = (state_q == StReq) & irq_ack_i & nm_q;
    assign nmi_pend_d = (irq_nm_i & ~nm_prev_q) | (nmi_pend_q & ~nmi_ack);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        nm_d    = nm_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (eligible) begin
                    state_d = StReq;
                    id_d    = best_id;
                    nm_d    = nmi_pend_q;
                end
            end
            StReq: begin
                if (irq_ack_i) begin
                    if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
                    state_d = nm_q ? StNmiSvc : StSvc;
                end else if (nmi_pend_q && !nm_q) begin
                    id_d = IdNmi;
                    nm_d = 1'b1;
                end else if (debug_mode_i ||
                             (!nm_q && (!csr_mstatus_mie_i || !src_active))) begin
                    state_d = StIdle;
                    nm_d    = 1'b0;
                end else if (best_id != id_q) begin
                    id_d = best_id;
                end
            end
            StSvc: begin
                if (nmi_pend_q && !debug_mode_i) begin
                    state_d = StReq;
                    id_d    = IdNmi;
                    nm_d    = 1'b1;
                end else if (mret_i) begin
                    state_d = StIdle;
                end
            end
            StNmiSvc: begin
                if (mret_i) begin
                    state_d = StIdle;
                    nm_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                nm_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            id_q       <= 6'd0;
            nm_q       <= 1'b0;
            nmi_pend_q <= 1'b0;
            nm_prev_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            nm_q       <= nm_d;
            nmi_pend_q <= nmi_pend_d;
            nm_prev_q  <= irq_nm_i;
            cnt_q      <= cnt_d;
        end
    end

    assign irq_req_o     = (state_q == StReq);
    assign irq_id_o      = id_q;
    assign irq_nm_o      = nm_q;
    assign irq_pending_o = (|en) | nmi_pend_q;
    assign busy_o        = (state_q != StIdle);
    assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Directed vector bench for ibex_irq_ctrl: default instance plus a narrow-counter,
// 32-line instance for counter saturation.
module tb_ibex_irq_ctrl;

    localparam logic [17:0] A = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        rst, sw, tim, ext, mm, nm, dbg, ack, mret;
    logic [14:0] fast;
    logic [17:0] mie;
    logic        req, nmo, pend, busy;
    logic [5:0]  id;
    logic [15:0] cnt;

    logic        rst_s, mm_s, ack_s, mret_s;
    logic [31:0] fast_s;
    logic [34:0] mie_s;
    logic        req_s, nmo_s, pend_s, busy_s;
    logic [5:0]  id_s;
    logic [3:0]  cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ibex_irq_ctrl dut (
        .clk_i(clk), .rst_i(rst), .irq_software_i(sw), .irq_timer_i(tim),
        .irq_external_i(ext), .irq_fast_i(fast), .irq_nm_i(nm), .csr_mstatus_mie_i(mm),
        .csr_mie_i(mie), .debug_mode_i(dbg), .irq_ack_i(ack), .mret_i(mret),
        .irq_req_o(req), .irq_id_o(id), .irq_nm_o(nmo), .irq_pending_o(pend),
        .busy_o(busy), .taken_cnt_o(cnt)
    );

    ibex_irq_ctrl #(.NUM_FAST_IRQ(32), .CNT_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst_s), .irq_software_i(1'b0), .irq_timer_i(1'b0),
        .irq_external_i(1'b0), .irq_fast_i(fast_s), .irq_nm_i(1'b0),
        .csr_mstatus_mie_i(mm_s), .csr_mie_i(mie_s), .debug_mode_i(1'b0),
        .irq_ack_i(ack_s), .mret_i(mret_s), .irq_req_o(req_s), .irq_id_o(id_s),
        .irq_nm_o(nmo_s), .irq_pending_o(pend_s), .busy_o(busy_s), .taken_cnt_o(cnt_s)
    );

    typedef struct {
        logic        rst, sw, tim, ext;
        logic [14:0] fast;
        logic        mm;
        logic [17:0] mie;
        logic        nm, dbg, ack, mret;
        logic        e_req;
        logic [5:0]  e_id;
        logic        cid;
        logic        e_nm, e_pend, e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic t, input logic e,
                                input logic [14:0] f, input logic m, input logic [17:0] mi,
                                input logic n, input logic d, input logic a, input logic mr,
                                input logic xr, input logic [5:0] xi, input logic c,
                                input logic xn, input logic xp, input logic xb,
                                input logic [15:0] xc);
        vec_t v;
        v.rst = r; v.sw = s; v.tim = t; v.ext = e; v.fast = f; v.mm = m; v.mie = mi;
        v.nm = n; v.dbg = d; v.ack = a; v.mret = mr;
        v.e_req = xr; v.e_id = xi; v.cid = c; v.e_nm = xn; v.e_pend = xp; v.e_busy = xb;
        v.e_cnt = xc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sw = 0; tim = 0; ext = 0; fast = '0; mm = 0; mie = '0;
        nm = 0; dbg = 0; ack = 0; mret = 0;
        rst_s = 1'b1; mm_s = 0; ack_s = 0; mret_s = 0; fast_s = '0; mie_s = '0;

        //   rst sw tm ex fast     mm mie nm db ak mr | req id  cid nm pnd bsy cnt
        // NMI held high through reset release: latched exactly once
        add(1, 0, 0, 0, 15'h0,   0, 0, 1, 0, 0, 0,   0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 15'h0,   0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 15'h0,   0, 0, 1, 0, 0, 0,   1, 63, 1, 1, 1, 1, 0);
        add(0, 0, 0, 0, 15'h0,   0, 0, 1, 0, 1, 0,   0, 0,  0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 15'h0,   0, 0, 1, 0, 0, 1,   0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 15'h0,   0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 15'h0,   0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 0, 0, 0);
        // priority: fast[9] beats fast[2], ext, sw, timer
        add(0, 0, 0, 0, 15'h0,   0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 15'h204, 1, A, 0, 0, 0, 0,   1, 25, 1, 0, 1, 1, 0);
        add(0, 1, 1, 1, 15'h204, 1, A, 0, 0, 1, 0,   0, 0,  0, 0, 1, 1, 1);
        add(0, 1, 1, 1, 15'h204, 1, A, 0, 0, 0, 1,   0, 0,  0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
        // withdraw
        add(0, 0, 1, 0, 15'h0,   1, A, 0, 0, 0, 0,   1, 7,  1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
        // NMI pre-emption, NMI service, NMI latched during service
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 0, 0,   1, 16, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 15'h1,   1, A, 1, 0, 0, 0,   1, 16, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 0, 0,   1, 63, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 1, 0,   0, 0,  0, 1, 1, 1, 2);
        add(0, 0, 0, 0, 15'h1,   1, A, 1, 0, 0, 0,   0, 0,  0, 1, 1, 1, 2);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 0, 0,   0, 0,  0, 1, 1, 1, 2);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 0, 1,   0, 0,  0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 0, 0,   1, 63, 1, 1, 1, 1, 2);
        add(0, 0, 0, 0, 15'h1,   1, A, 0, 0, 1, 0,   0, 0,  0, 1, 1, 1, 3);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 1,   0, 0,  0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 3);
        // debug suppression and withdraw, ack ignored in SVC, reset mid-SVC
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 1, 0, 0,   0, 0,  0, 0, 1, 0, 3);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 0, 0, 0,   1, 11, 1, 0, 1, 1, 3);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 1, 0, 0,   0, 0,  0, 0, 1, 0, 3);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 0, 0, 0,   1, 11, 1, 0, 1, 1, 3);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 0, 1, 0,   0, 0,  0, 0, 1, 1, 4);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 1, 1, 4);
        add(0, 0, 0, 1, 15'h0,   1, A, 0, 0, 1, 0,   0, 0,  0, 0, 1, 1, 4);
        add(1, 0, 0, 0, 15'h0,   0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 15'h0,   0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
        // re-latch to higher source, mret ignored in REQ, per-source mask
        add(0, 0, 1, 0, 15'h0,   1, A, 0, 0, 0, 0,   1, 7,  1, 0, 1, 1, 0);
        add(0, 0, 1, 1, 15'h0,   1, A, 0, 0, 0, 0,   1, 11, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, 15'h0,   1, A, 0, 0, 0, 1,   1, 11, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, 15'h0,   1, A, 0, 0, 1, 0,   0, 0,  0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 1,   0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 15'h0,   1, 18'h3FFFB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
        // NMI nesting out of a software-irq service
        add(0, 1, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   1, 3,  1, 0, 1, 1, 1);
        add(0, 1, 0, 0, 15'h0,   1, A, 0, 0, 1, 0,   0, 0,  0, 0, 1, 1, 2);
        add(0, 1, 0, 0, 15'h0,   1, A, 1, 0, 0, 0,   0, 0,  0, 0, 1, 1, 2);
        add(0, 1, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   1, 63, 1, 1, 1, 1, 2);
        add(0, 1, 0, 0, 15'h0,   1, A, 0, 0, 1, 0,   0, 0,  0, 1, 1, 1, 3);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 1,   0, 0,  0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 15'h0,   1, A, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 3);

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; sw = vecs[i].sw; tim = vecs[i].tim; ext = vecs[i].ext;
            fast = vecs[i].fast; mm = vecs[i].mm; mie = vecs[i].mie; nm = vecs[i].nm;
            dbg = vecs[i].dbg; ack = vecs[i].ack; mret = vecs[i].mret;
            tick();
            check("req", i, 32'(req), 32'(vecs[i].e_req));
            if (vecs[i].cid) check("id", i, 32'(id), 32'(vecs[i].e_id));
            check("nm", i, 32'(nmo), 32'(vecs[i].e_nm));
            check("pending", i, 32'(pend), 32'(vecs[i].e_pend));
            check("busy", i, 32'(busy), 32'(vecs[i].e_busy));
            check("cnt", i, 32'(cnt), 32'(vecs[i].e_cnt));
        end

        // Globally masked external irq: wakeup only, then request once mie is set
        ext = 1; mie = 18'h4; mm = 0; nm = 0; ack = 0; mret = 0; dbg = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mask_req", i, 32'(req), 32'd0);
        end
        check("mask_pend", 0, 32'(pend), 32'd1);
        mm = 1;
        tick();
        check("mask_req_on", 0, 32'(req), 32'd1);
        check("mask_id", 0, 32'(id), 32'd11);
        ack = 1;
        tick();
        check("mask_cnt", 0, 32'(cnt), 32'd4);
        ack = 0; mret = 1; ext = 0;
        tick();
        check("mask_busy", 0, 32'(busy), 32'd0);
        mret = 0;

        // Counter saturation on the 4-bit, 32-line instance
        check("sat_rst_cnt", 0, 32'(cnt_s), 32'd0);
        rst_s = 0; mm_s = 1; mie_s = '1; fast_s = 32'h8000_0000;
        for (int i = 0; i < 17; i++) begin
            ack_s = 0; mret_s = 0;
            tick();
            check("sat_req", i, 32'(req_s), 32'd1);
            check("sat_id", i, 32'(id_s), 32'd47);
            ack_s = 1;
            tick();
            check("sat_cnt", i, 32'(cnt_s), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            ack_s = 0; mret_s = 1;
            tick();
            check("sat_busy", i, 32'(busy_s), 32'd0);
        end
        mret_s = 0;
        check("sat_final", 0, 32'(cnt_s), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
